// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Transmit serializer. Pops one word per frame from a byte FIFO
//   (rd_en/empty handshake, one-cycle read latency), then drives start,
//   data (LSB first), optional parity and stop bits onto the TX line.
//   A byte is popped only when the engine can send it right away.
//
// Ports
//   clk        : PLL clock
//   rst        : asynchronous reset, active low
//   enable     : lets new frames start; a frame in flight always completes
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en : single-cycle pop strobe
//   tx         : serial line, idle high
//   busy       : high from FETCH through the end of the last stop bit
//   frame_done : one-cycle pulse after the last stop bit

module uart_tx_engine #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  generate
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        DATA_BITS < 5 || DATA_BITS > 8 || CPB < 2) begin : g_bad_params
      $error("uart_tx_engine: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_d, rd_en_d, busy_d, done_d;
  logic                 bit_end;
  logic                 go;

  assign bit_end = (cnt_q == CNT_LAST);
  // The FIFO and enable are only looked at when a new frame may start.
  assign go      = enable && !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (go) state_d = S_FETCH;
      end
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        shift_d = fifo_data[DATA_BITS-1:0];
        par_d   = (PARITY == 1) ? ~^fifo_data[DATA_BITS-1:0]
                                :  ^fifo_data[DATA_BITS-1:0];
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // idx_q counts stop bits so the baud counter never exceeds one bit.
        if (bit_end) begin
          if (idx_q == 3'(STOP_BITS - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = go ? S_FETCH : S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they line
    // up with the state register and are glitch-free.
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

endmodule
